// File: rtl/inst_mem_pkg.sv
// +----------------------------------------------------------------------------+
// | inst_mem_pkg: shared types and constants for the instruction memory loader. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package inst_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] c_ERR_OK       = 2'b00;
   localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
   localparam logic [1:0] c_ERR_RANGE    = 2'b10;
   localparam logic [1:0] c_ERR_PARITY   = 2'b11;

   localparam logic [31:0] c_NOP = 32'h0000_0013;

   // Even parity over up to 64 bits; callers zero-extend, which leaves the XOR unchanged.
   function automatic logic even_parity(input logic [63:0] data);
      return ^data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/inst_mem_array.sv
// +----------------------------------------------------------------------------+
// | inst_mem_array: simple dual-port RAM, one write port, one registered read.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module inst_mem_array #(
   parameter int WIDTH = 32,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [2**AW];

   // No reset on storage or read register so the tools map this onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= r_mem[raddr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// +----------------------------------------------------------------------------+
// | inst_mem_loader: registered instruction memory with fetch and burst-load    |
// | ports. Optional INST_MEM_PARITY_EN adds an even-parity bit per word.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module inst_mem_loader
   import inst_mem_pkg::*;
#(
   parameter int              XLEN  = 32,
   parameter int              DEPTH = 8,
   parameter logic [XLEN-1:0] NOP   = XLEN'(c_NOP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_req,
   input  logic [XLEN-1:0]  fetch_pc,
   output logic             fetch_ready,
   output logic             fetch_valid,
   output logic [XLEN-1:0]  fetch_inst,
   output logic [1:0]       fetch_err,
   input  logic             ld_start,
   input  logic [XLEN-1:0]  ld_base,
   input  logic [DEPTH:0]   ld_len,
   input  logic             ld_valid,
   input  logic [XLEN-1:0]  ld_data,
   output logic             ld_ready,
   output logic             ld_done,
   output logic             ld_err,
   output logic             busy
);

`ifdef INST_MEM_PARITY_EN
   localparam int c_MEM_W = XLEN + 1;
`else
   localparam int c_MEM_W = XLEN;
`endif

   localparam logic [XLEN-3:0] c_WA_ONE  = {{(XLEN-3){1'b0}}, 1'b1};
   localparam logic [DEPTH:0]  c_LEN_ONE = {{DEPTH{1'b0}}, 1'b1};

   state_t            r_state;
   logic [XLEN-3:0]   r_waddr;
   logic [DEPTH:0]    r_remain;
   logic              r_ld_err;
   logic              r_fetch_valid;
   logic [1:0]        r_fetch_code;
   logic              r_fetch_nop;

   logic              w_waddr_oob;
   logic              w_we;
   logic [c_MEM_W-1:0] w_wdata;
   logic              w_fetch_acc;
   logic [1:0]        w_fetch_code;
   logic              w_re;
   logic [c_MEM_W-1:0] w_rdata;
   logic              w_par_bad;
   logic              w_unused_base;

   assign w_unused_base = ^ld_base[1:0];

   // Word index kept wide so addresses past the array are detected rather than wrapped.
   assign w_waddr_oob = |r_waddr[XLEN-3:DEPTH];
   assign w_we        = (r_state == ST_LOAD) && ld_valid && !w_waddr_oob;

`ifdef INST_MEM_PARITY_EN
   assign w_wdata = {even_parity(64'(ld_data)), ld_data};
`else
   assign w_wdata = ld_data;
`endif

   assign w_fetch_acc  = fetch_req && (r_state == ST_IDLE);
   assign w_fetch_code = (|fetch_pc[1:0])            ? c_ERR_MISALIGN :
                         (|fetch_pc[XLEN-1:DEPTH+2]) ? c_ERR_RANGE    : c_ERR_OK;
   assign w_re         = w_fetch_acc && (w_fetch_code == c_ERR_OK);

   inst_mem_array #(
      .WIDTH (c_MEM_W),
      .AW    (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (w_we),
      .waddr (r_waddr[DEPTH-1:0]),
      .wdata (w_wdata),
      .re    (w_re),
      .raddr (fetch_pc[DEPTH+1:2]),
      .rdata (w_rdata)
   );

`ifdef INST_MEM_PARITY_EN
   assign w_par_bad = !r_fetch_nop &&
                      (even_parity(64'(w_rdata[XLEN-1:0])) != w_rdata[XLEN]);
`else
   assign w_par_bad = 1'b0;
`endif

   // RAM output only changes on a good fetch, so the response holds between fetches.
   assign fetch_valid = r_fetch_valid;
   assign fetch_inst  = (r_fetch_nop || w_par_bad) ? NOP : w_rdata[XLEN-1:0];
   assign fetch_err   = w_par_bad ? c_ERR_PARITY : r_fetch_code;
   assign fetch_ready = (r_state == ST_IDLE);
   assign ld_ready    = (r_state == ST_LOAD);
   assign ld_done     = (r_state == ST_DONE);
   assign ld_err      = r_ld_err && (r_state == ST_DONE);
   assign busy        = (r_state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_valid <= 1'b0;
         r_fetch_code  <= c_ERR_OK;
         r_fetch_nop   <= 1'b1;
      end else begin
         r_fetch_valid <= w_fetch_acc;
         if (w_fetch_acc) begin
            r_fetch_code <= w_fetch_code;
            r_fetch_nop  <= (w_fetch_code != c_ERR_OK);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_waddr  <= '0;
         r_remain <= '0;
         r_ld_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ld_start) begin
                  r_waddr  <= ld_base[XLEN-1:2];
                  r_remain <= ld_len;
                  r_ld_err <= 1'b0;
                  r_state  <= (ld_len == '0) ? ST_DONE : ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (ld_valid) begin
                  if (w_waddr_oob) begin
                     r_ld_err <= 1'b1;
                  end
                  r_waddr  <= r_waddr + c_WA_ONE;
                  r_remain <= r_remain - c_LEN_ONE;
                  if (r_remain == c_LEN_ONE) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
